dmem_bridge: RTL and testbench

Data-memory bus bridge sitting directly downstream of the MEM stage. It converts MEM's single-cycle combinational request (chip-enable, write-enable, byte select, address, write data) into a multi-cycle SRAM-like handshake (req / addr_ok / data_ok). While the transaction is outstanding it holds the pipeline with a stall request. It returns registered load data that MEM consumes as its RAM read word.

---
 rtl/dmem_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: converts the MEM stage's single-cycle data-memory request into
// an SRAM-like req / addr_ok / data_ok bus transaction, holding the pipeline
// with stall_req_o while the access is outstanding and returning a registered
// load word to MEM.
//
// Optional feature: define DMEM_TIMEOUT_EN to build a bus watchdog that aborts
// a transaction after TIMEOUT_CYCLES cycles without data_ok. When it is not
// defined, bus_err_o is tied low and the bridge waits indefinitely.
module dmem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    // MEM-stage request
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_exc_i,
    input  logic        flush_i,
    // Pipeline side
    output logic        stall_req_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        bus_err_o,
    // SRAM-like bus
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_data_ok_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic cancel;     // outstanding transaction belongs to a flushed instruction
    logic new_req;    // MEM presents a request that is allowed to go out
    logic in_flight;  // REQ or WAIT: bus transaction outstanding
    logic data_done;  // data phase of the outstanding transaction ends this cycle
    logic kill;       // the completing transaction must not reach the pipeline
    logic timeout;    // watchdog expires this cycle

    // Byte-lane select to bus size: single lanes are bytes, aligned lane
    // pairs are halves, everything else (including odd patterns) is a word.
    function automatic logic [1:0] sel_to_size(input logic [3:0] sel);
        logic [1:0] size;
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 2'd0;
            4'b0011, 4'b1100:                   size = 2'd1;
            default:                            size = 2'd2;
        endcase
        return size;
    endfunction

    // Request qualification and transaction-completion decode
    always_comb begin
        new_req   = mem_ce_i & ~mem_exc_i & ~flush_i;
        in_flight = (state == REQ) || (state == WAIT);
        data_done = ((state == REQ)  && data_addr_ok_i && data_data_ok_i) ||
                    ((state == WAIT) && data_data_ok_i);
        // A flush arriving in the very cycle data_ok returns also discards it.
        kill      = cancel | flush_i;
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt;

    // Watchdog counter: cleared on entry to REQ, counts every in-flight cycle
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            wd_cnt <= '0;
        end else if (state == IDLE) begin
            wd_cnt <= '0;
        end else if (in_flight) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    // Expire on the TIMEOUT_CYCLES-th in-flight cycle; data_ok takes priority
    always_comb begin
        timeout = in_flight && !data_done &&
                  (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // One-cycle abort pulse, coincident with the following DONE cycle
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= timeout;
        end
    end
`else
    // Without the watchdog nothing ever expires (the limit can never be < 0)
    always_comb begin
        timeout = (TIMEOUT_CYCLES < 0);
    end

    assign bus_err_o = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (new_req) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (data_done || timeout) begin
                    next_state = kill ? IDLE : DONE;
                end else if (data_addr_ok_i) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (data_done || timeout) begin
                    next_state = kill ? IDLE : DONE;
                end
            end
            DONE: begin
                // The same instruction still drives mem_ce_i here; ignore it.
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // FSM combinational output: hold the pipeline while an access is pending
    always_comb begin
        stall_req_o = ((state == IDLE) && new_req) || in_flight;
    end

    // Cancel flag: set by a flush while in flight, cleared once the drain ends
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            cancel <= 1'b0;
        end else begin
            cancel <= in_flight && (next_state != IDLE) && (next_state != DONE) &&
                      (cancel || flush_i);
        end
    end

    // Registered bus request and completion pulse, derived from the next state
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            data_req_o    <= 1'b0;
            rdata_valid_o <= 1'b0;
        end else begin
            data_req_o    <= (next_state == REQ);
            rdata_valid_o <= (next_state == DONE);
        end
    end

    // Request latch: captured once when the request is accepted in IDLE
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            data_wr_o    <= 1'b0;
            data_size_o  <= 2'd0;
            data_addr_o  <= 32'd0;
            data_wdata_o <= 32'd0;
        end else if ((state == IDLE) && new_req) begin
            data_wr_o    <= mem_we_i;
            data_size_o  <= sel_to_size(mem_sel_i);
            data_addr_o  <= mem_addr_i;
            data_wdata_o <= mem_data_i;
        end
    end

    // Load-data register: updated only by a completing, non-cancelled load
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            rdata_o <= 32'd0;
        end else if (data_done && !kill && !data_wr_o) begin
            rdata_o <= data_rdata_i;
        end else if (timeout && !kill && !data_wr_o) begin
            rdata_o <= 32'hDEADBEEF;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed testbench for dmem_bridge. The bench plays both the MEM stage and
// the bus slave, driving inputs just after the rising edge and sampling the
// outputs on the falling edge. Build with +define+DMEM_TIMEOUT_EN to exercise
// the watchdog (instantiated with an 8-cycle limit).
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, we, exc, flush;
    logic [3:0]  sel;
    logic [31:0] addr, wdata;
    logic        stall, rdata_valid, bus_err;
    logic [31:0] rdata;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] baddr, bwdata;
    logic        addr_ok, data_ok;
    logic [31:0] bus_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    dmem_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .cpu_clk_50M    (clk),
        .cpu_rst        (rst),
        .mem_ce_i       (ce),
        .mem_we_i       (we),
        .mem_sel_i      (sel),
        .mem_addr_i     (addr),
        .mem_data_i     (wdata),
        .mem_exc_i      (exc),
        .flush_i        (flush),
        .stall_req_o    (stall),
        .rdata_o        (rdata),
        .rdata_valid_o  (rdata_valid),
        .bus_err_o      (bus_err),
        .data_req_o     (req),
        .data_wr_o      (wr),
        .data_size_o    (size),
        .data_addr_o    (baddr),
        .data_wdata_o   (bwdata),
        .data_addr_ok_i (addr_ok),
        .data_rdata_i   (bus_rdata),
        .data_data_ok_i (data_ok)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ce = 1'b0; we = 1'b0; exc = 1'b0; flush = 1'b0;
        sel = 4'h0; addr = 32'd0; wdata = 32'd0;
        addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = 32'd0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        total_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else pass_cnt++;
        total_cnt++; if (rdata !== 32'd0) $display("FAIL rst_rdata: got %h want 0", rdata); else pass_cnt++;
        total_cnt++; if (rdata_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", rdata_valid); else pass_cnt++;
        total_cnt++; if (bus_err !== 1'b0) $display("FAIL rst_bus_err: got %b want 0", bus_err); else pass_cnt++;
        total_cnt++; if (req !== 1'b0) $display("FAIL rst_req: got %b want 0", req); else pass_cnt++;
        total_cnt++; if ({wr, size} !== 3'b000) $display("FAIL rst_wr_size: got %b want 000", {wr, size}); else pass_cnt++;
        total_cnt++; if ({baddr, bwdata} !== 64'd0) $display("FAIL rst_addr_wdata: got %h want 0", {baddr, bwdata}); else pass_cnt++;
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_zero_wait_load;
        int stall_cycles = 0;
        // IDLE: request presented
        ce = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h0000_1004;
        @(negedge clk);
        stall_cycles += int'(stall);
        total_cnt++; if (stall !== 1'b1) $display("FAIL zw_stall_idle: got %b want 1", stall); else pass_cnt++;
        total_cnt++; if (req !== 1'b0) $display("FAIL zw_req_idle: got %b want 0", req); else pass_cnt++;
        next_cycle();
        // REQ: slave answers address and data at once
        addr_ok = 1'b1; data_ok = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        stall_cycles += int'(stall);
        total_cnt++; if (req !== 1'b1) $display("FAIL zw_req: got %b want 1", req); else pass_cnt++;
        total_cnt++; if (size !== 2'd2) $display("FAIL zw_size: got %0d want 2", size); else pass_cnt++;
        total_cnt++; if (baddr !== 32'h0000_1004) $display("FAIL zw_addr: got %h want 00001004", baddr); else pass_cnt++;
        total_cnt++; if (wr !== 1'b0) $display("FAIL zw_wr: got %b want 0", wr); else pass_cnt++;
        next_cycle();
        addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = 32'd0;
        // DONE
        @(negedge clk);
        stall_cycles += int'(stall);
        total_cnt++; if (rdata !== 32'h1234_5678) $display("FAIL zw_rdata: got %h want 12345678", rdata); else pass_cnt++;
        total_cnt++; if (rdata_valid !== 1'b1) $display("FAIL zw_valid_done: got %b want 1", rdata_valid); else pass_cnt++;
        total_cnt++; if (req !== 1'b0) $display("FAIL zw_req_done: got %b want 0", req); else pass_cnt++;
        next_cycle();
        ce = 1'b0;
        // back in IDLE
        @(negedge clk);
        total_cnt++; if (rdata_valid !== 1'b0) $display("FAIL zw_valid_pulse: got %b want 0", rdata_valid); else pass_cnt++;
        total_cnt++; if (stall_cycles != 2) $display("FAIL zw_stall_cycles: got %0d want 2", stall_cycles); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_store_delays;
        int req_cycles = 0;
        int stall_cycles = 0;
        we = 1'b1; sel = 4'b1000; addr = 32'h0000_2003; wdata = 32'hAB00_0000;
        for (int i = 0; i < 8; i++) begin
            ce      = (i <= 6);
            addr_ok = (i == 3);
            data_ok = (i == 5);
            @(negedge clk);
            req_cycles   += int'(req);
            stall_cycles += int'(stall);
            if (i == 3) begin
                total_cnt++; if (wr !== 1'b1) $display("FAIL sb_wr: got %b want 1", wr); else pass_cnt++;
                total_cnt++; if (size !== 2'd0) $display("FAIL sb_size: got %0d want 0", size); else pass_cnt++;
                total_cnt++; if (baddr !== 32'h0000_2003) $display("FAIL sb_addr: got %h want 00002003", baddr); else pass_cnt++;
                total_cnt++; if (bwdata !== 32'hAB00_0000) $display("FAIL sb_wdata: got %h want ab000000", bwdata); else pass_cnt++;
            end
            if (i == 6) begin
                total_cnt++; if (stall !== 1'b0) $display("FAIL sb_stall_done: got %b want 0", stall); else pass_cnt++;
                total_cnt++; if (rdata !== 32'h1234_5678) $display("FAIL sb_rdata_kept: got %h want 12345678", rdata); else pass_cnt++;
            end
            if (i == 7) begin
                total_cnt++; if ({stall, req} !== 2'b00) $display("FAIL sb_idle_after: got %b want 00", {stall, req}); else pass_cnt++;
            end
            next_cycle();
        end
        idle_inputs();
        total_cnt++; if (req_cycles != 3) $display("FAIL sb_req_cycles: got %0d want 3", req_cycles); else pass_cnt++;
        total_cnt++; if (stall_cycles != 6) $display("FAIL sb_stall_cycles: got %0d want 6", stall_cycles); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] t_addr [3];
        logic [3:0]  t_sel  [3];
        logic [31:0] t_data [3];
        logic [1:0]  t_size [3];
        t_addr = '{32'h0000_3000, 32'h0000_3001, 32'h0000_3004};
        t_sel  = '{4'b0011, 4'b0010, 4'b0110};
        t_data = '{32'h0000_BEEF, 32'h0000_5500, 32'h1122_3344};
        t_size = '{2'd1, 2'd0, 2'd2};
        we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            // IDLE (for k > 0 this is the cycle right after the previous DONE)
            ce = 1'b1; sel = t_sel[k]; addr = t_addr[k];
            @(negedge clk);
            total_cnt++; if (stall !== 1'b1) $display("FAIL b2b_stall_idle[%0d]: got %b want 1", k, stall); else pass_cnt++;
            next_cycle();
            addr_ok = 1'b1; data_ok = 1'b1; bus_rdata = t_data[k];
            @(negedge clk);
            total_cnt++; if (size !== t_size[k]) $display("FAIL b2b_size[%0d]: got %0d want %0d", k, size, t_size[k]); else pass_cnt++;
            total_cnt++; if (baddr !== t_addr[k]) $display("FAIL b2b_addr[%0d]: got %h want %h", k, baddr, t_addr[k]); else pass_cnt++;
            next_cycle();
            addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = 32'd0;
            @(negedge clk);
            total_cnt++; if (rdata !== t_data[k]) $display("FAIL b2b_rdata[%0d]: got %h want %h", k, rdata, t_data[k]); else pass_cnt++;
            total_cnt++; if (stall !== 1'b0) $display("FAIL b2b_stall_done[%0d]: got %b want 0", k, stall); else pass_cnt++;
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_suppressed;
        ce = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h0000_7000;
        for (int i = 0; i < 6; i++) begin
            exc   = (i < 3);
            flush = (i >= 3);
            @(negedge clk);
            total_cnt++; if ({stall, req} !== 2'b00) $display("FAIL sup_stall_req[%0d]: got %b want 00", i, {stall, req}); else pass_cnt++;
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        total_cnt++; if (req !== 1'b0) $display("FAIL sup_req_after: got %b want 0", req); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h1122_3344) $display("FAIL sup_rdata: got %h want 11223344", rdata); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_flush_drain;
        ce = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h0000_4000;
        next_cycle();
        // REQ: address accepted
        addr_ok = 1'b1;
        @(negedge clk);
        total_cnt++; if (req !== 1'b1) $display("FAIL fl_req: got %b want 1", req); else pass_cnt++;
        next_cycle();
        addr_ok = 1'b0;
        // WAIT: flush pulse, MEM instruction is gone afterwards
        flush = 1'b1;
        @(negedge clk);
        total_cnt++; if (stall !== 1'b1) $display("FAIL fl_stall_flush: got %b want 1", stall); else pass_cnt++;
        next_cycle();
        flush = 1'b0; ce = 1'b0;
        @(negedge clk);
        total_cnt++; if (stall !== 1'b1) $display("FAIL fl_stall_drain: got %b want 1", stall); else pass_cnt++;
        next_cycle();
        data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        total_cnt++; if (stall !== 1'b1) $display("FAIL fl_stall_dataok: got %b want 1", stall); else pass_cnt++;
        next_cycle();
        data_ok = 1'b0; bus_rdata = 32'd0;
        @(negedge clk);
        total_cnt++; if ({stall, rdata_valid, req} !== 3'b000) $display("FAIL fl_idle: got %b want 000", {stall, rdata_valid, req}); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h1122_3344) $display("FAIL fl_rdata_kept: got %h want 11223344", rdata); else pass_cnt++;
        next_cycle();
        // A following load must complete normally
        ce = 1'b1; addr = 32'h0000_4004;
        next_cycle();
        addr_ok = 1'b1; data_ok = 1'b1; bus_rdata = 32'h0BAD_F00D;
        next_cycle();
        addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = 32'd0;
        @(negedge clk);
        total_cnt++; if (rdata_valid !== 1'b1) $display("FAIL fl_next_valid: got %b want 1", rdata_valid); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h0BAD_F00D) $display("FAIL fl_next_rdata: got %h want 0badf00d", rdata); else pass_cnt++;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid;
        ce = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h0000_5000;
        next_cycle();
        // REQ, no addr_ok; reset arrives this cycle
        rst = 1'b1; ce = 1'b0;
        @(negedge clk);
        total_cnt++; if (req !== 1'b1) $display("FAIL rm_req_before: got %b want 1", req); else pass_cnt++;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if ({req, stall, rdata_valid} !== 3'b000) $display("FAIL rm_ctrl: got %b want 000", {req, stall, rdata_valid}); else pass_cnt++;
        total_cnt++; if (rdata !== 32'd0) $display("FAIL rm_rdata: got %h want 0", rdata); else pass_cnt++;
        total_cnt++; if (baddr !== 32'd0) $display("FAIL rm_addr: got %h want 0", baddr); else pass_cnt++;
        next_cycle();
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_watchdog;
        int err_cycles = 0;
        int err_first  = -1;
        we = 1'b0; sel = 4'hF; addr = 32'h0000_6000;
        for (int i = 0; i < 12; i++) begin
            ce      = (i <= 9);
            addr_ok = (i == 1);
            @(negedge clk);
            if (bus_err === 1'b1) begin
                err_cycles++;
                if (err_first < 0) err_first = i;
            end
            if (i == 9) begin
                total_cnt++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL wd_rdata: got %h want deadbeef", rdata); else pass_cnt++;
                total_cnt++; if (stall !== 1'b0) $display("FAIL wd_stall_done: got %b want 0", stall); else pass_cnt++;
            end
            if (i == 10) begin
                total_cnt++; if ({stall, req} !== 2'b00) $display("FAIL wd_idle: got %b want 00", {stall, req}); else pass_cnt++;
            end
            next_cycle();
        end
        idle_inputs();
        total_cnt++; if (err_first != 9) $display("FAIL wd_err_cycle: got %0d want 9", err_first); else pass_cnt++;
        total_cnt++; if (err_cycles != 1) $display("FAIL wd_err_width: got %0d want 1", err_cycles); else pass_cnt++;
    endtask
`else
    task automatic test_no_timeout;
        int err_cycles = 0;
        int stall_cycles = 0;
        we = 1'b0; sel = 4'hF; addr = 32'h0000_6000;
        for (int i = 0; i < 25; i++) begin
            ce        = (i <= 23);
            addr_ok   = (i == 1);
            data_ok   = (i == 22);
            bus_rdata = (i == 22) ? 32'h5A5A_5A5A : 32'd0;
            @(negedge clk);
            err_cycles   += int'(bus_err);
            stall_cycles += int'(stall);
            if (i == 23) begin
                total_cnt++; if (rdata !== 32'h5A5A_5A5A) $display("FAIL nt_rdata: got %h want 5a5a5a5a", rdata); else pass_cnt++;
                total_cnt++; if (rdata_valid !== 1'b1) $display("FAIL nt_valid: got %b want 1", rdata_valid); else pass_cnt++;
            end
            next_cycle();
        end
        idle_inputs();
        total_cnt++; if (err_cycles != 0) $display("FAIL nt_bus_err: got %0d want 0", err_cycles); else pass_cnt++;
        total_cnt++; if (stall_cycles != 23) $display("FAIL nt_stall_cycles: got %0d want 23", stall_cycles); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait_load();
        test_store_delays();
        test_back_to_back();
        test_suppressed();
        test_flush_drain();
        test_reset_mid();
`ifdef DMEM_TIMEOUT_EN
        test_watchdog();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish want finish");
        $fatal(1, "simulation time limit");
    end

endmodule
